// File: rtl/ysyx_22040125_stall_ctrl.sv
// ysyx_22040125_stall_ctrl
//
// Pipeline interlock generator for the 5-stage RV64 core. It detects
// load-use hazards and waits for multi-cycle mul/div results and
// data-memory accesses. Branch flushes are held back behind those waits.
//
// Ports:
//   clk, rst_n           core clock, asynchronous active-low reset
//   id_rs1/2, *_used     source registers of the ID instruction
//   ex_rd, ex_mem_read,
//   ex_reg_wen           destination/load info of the EX instruction
//   md_start, md_done    mul/div issue pulse and result-valid strobe
//   mem_req, mem_ready   data-memory access request and completion
//   branch_flush         taken branch/jump resolved in EX (pulse)
//   stall                freeze PC, IF/ID, ID/EX and EX
//   bubble               load ID/EX with a NOP
//   flush                squash IF/ID and ID/EX
//   perf_stall_cnt       stalled-cycle counter (YSYX_22040125_STALL_PERF_EN only)
//
// Configuration macro: YSYX_22040125_STALL_PERF_EN adds the perf counter.

module ysyx_22040125_stall_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_rs1_used,
  input  logic        id_rs2_used,
  input  logic [4:0]  ex_rd,
  input  logic        ex_mem_read,
  input  logic        ex_reg_wen,
  input  logic        md_start,
  input  logic        md_done,
  input  logic        mem_req,
  input  logic        mem_ready,
  input  logic        branch_flush,
  output logic        stall,
  output logic        bubble,
`ifdef YSYX_22040125_STALL_PERF_EN
  output logic        flush,
  output logic [31:0] perf_stall_cnt
`else
  output logic        flush
`endif
);

  // State is the pair {md_busy, mem_busy}; each flag tracks one outstanding wait.
  localparam logic [1:0] RUN       = 2'b00;
  localparam logic [1:0] MEM_WAIT  = 2'b01;
  localparam logic [1:0] MD_WAIT   = 2'b10;
  localparam logic [1:0] BOTH_WAIT = 2'b11;

  logic [1:0] state;
  logic       flush_pend;

  logic       mem_busy;
  logic       md_busy;
  logic       lu;
  logic       lu_eff;
  logic       mem_hold;
  logic       md_hold;
  logic       hard;

  assign mem_busy = (state == MEM_WAIT) | (state == BOTH_WAIT);
  assign md_busy  = (state == MD_WAIT)  | (state == BOTH_WAIT);

  // Load-use hazard: the ID instruction reads a register the EX load is about to write.
  assign lu = ex_mem_read & ex_reg_wen & (ex_rd != 5'd0) &
              ((id_rs1_used & (id_rs1 == ex_rd)) |
               (id_rs2_used & (id_rs2 == ex_rd)));

  // A wait starts on the request itself, so a same-cycle completion never stalls.
  assign mem_hold = (mem_busy | mem_req)  & ~mem_ready;
  assign md_hold  = (md_busy  | md_start) & ~md_done;
  assign hard     = mem_hold | md_hold;

  // The ID instruction is being killed, so its load-use stall is pointless.
  assign lu_eff = lu & ~branch_flush & ~flush_pend;

  // Outputs are gated by rst_n so they read 0 throughout reset.
  assign stall  = rst_n & (hard | lu_eff);
  assign bubble = rst_n & lu_eff & ~hard;
  assign flush  = rst_n & (branch_flush | flush_pend) & ~hard;

  // A flush that arrives during a hard wait is remembered until the wait
  // ends; it is cleared in the first cycle without hard, which is exactly
  // the cycle flush is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      flush_pend <= 1'b0;
    end else begin
      state      <= {md_hold, mem_hold};
      flush_pend <= hard & (flush_pend | branch_flush);
    end
  end

`ifdef YSYX_22040125_STALL_PERF_EN
  // Free-running stalled-cycle counter; wraps naturally at 32 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt <= 32'd0;
    end else if (stall) begin
      perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_22040125_stall_ctrl.sv
// tb_ysyx_22040125_stall_ctrl
//
// Directed and randomized bench for ysyx_22040125_stall_ctrl. Expected
// outputs come from a behavioural model that tracks "is a memory access
// outstanding", "is a mul/div outstanding", "is a flush owed" and the
// stalled-cycle total. Define YSYX_22040125_STALL_PERF_EN to also check
// perf_stall_cnt.

module tb_ysyx_22040125_stall_ctrl;

  logic        clk;
  logic        rst_n;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_rs1_used;
  logic        id_rs2_used;
  logic [4:0]  ex_rd;
  logic        ex_mem_read;
  logic        ex_reg_wen;
  logic        md_start;
  logic        md_done;
  logic        mem_req;
  logic        mem_ready;
  logic        branch_flush;
  logic        stall;
  logic        bubble;
  logic        flush;
`ifdef YSYX_22040125_STALL_PERF_EN
  logic [31:0] perf_stall_cnt;
`endif

  int tests;
  int fails;

  // Reference model state
  bit          memOutstanding;
  bit          mdOutstanding;
  bit          flushOwed;
  logic [31:0] stallTotal;

  // Observed-event tallies for window checks
  int stallSeen;
  int bubbleSeen;
  int flushSeen;

  ysyx_22040125_stall_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_rs1_used    (id_rs1_used),
    .id_rs2_used    (id_rs2_used),
    .ex_rd          (ex_rd),
    .ex_mem_read    (ex_mem_read),
    .ex_reg_wen     (ex_reg_wen),
    .md_start       (md_start),
    .md_done        (md_done),
    .mem_req        (mem_req),
    .mem_ready      (mem_ready),
    .branch_flush   (branch_flush),
    .stall          (stall),
    .bubble         (bubble),
`ifdef YSYX_22040125_STALL_PERF_EN
    .flush          (flush),
    .perf_stall_cnt (perf_stall_cnt)
`else
    .flush          (flush)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts the test and reports any failure.
  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("[TB] %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Return all inputs to an idle pattern (reset stays as it is).
  task automatic clearInputs;
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
    ex_rd = 5'd0; ex_mem_read = 1'b0; ex_reg_wen = 1'b0;
    md_start = 1'b0; md_done = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    branch_flush = 1'b0;
  endtask

  // Compare the combinational outputs against the model for the current
  // inputs, then move the model across the coming clock edge.
  task automatic checkOutput(input string tag);
    bit hazard, memWait, mdWait, frozen, killLu;
    bit expStall, expBubble, expFlush;
    if (!rst_n) begin
      memOutstanding = 0; mdOutstanding = 0; flushOwed = 0; stallTotal = 32'd0;
    end
    hazard = ex_mem_read && ex_reg_wen && ex_rd != 0 &&
             ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));
    memWait = (memOutstanding || mem_req) && !mem_ready;
    mdWait  = (mdOutstanding || md_start) && !md_done;
    frozen  = memWait || mdWait;
    killLu  = branch_flush || flushOwed;
    if (!rst_n) begin
      expStall = 0; expBubble = 0; expFlush = 0;
    end else begin
      expStall  = frozen || (hazard && !killLu);
      expBubble = !frozen && hazard && !killLu;
      expFlush  = !frozen && killLu;
    end
    checkVal({tag, ".stall"},  {31'd0, stall},  {31'd0, expStall});
    checkVal({tag, ".bubble"}, {31'd0, bubble}, {31'd0, expBubble});
    checkVal({tag, ".flush"},  {31'd0, flush},  {31'd0, expFlush});
`ifdef YSYX_22040125_STALL_PERF_EN
    checkVal({tag, ".perf"}, perf_stall_cnt, stallTotal);
`endif
    stallSeen  += int'(stall);
    bubbleSeen += int'(bubble);
    flushSeen  += int'(flush);
    if (rst_n) begin
      memOutstanding = memWait;
      mdOutstanding  = mdWait;
      flushOwed      = frozen && (flushOwed || branch_flush);
      if (expStall) stallTotal = stallTotal + 32'd1;
    end
  endtask

  // One cycle: inputs are already set at the negedge; check, then cross posedge.
  task automatic applyStimulus(input string tag);
    #1;
    checkOutput(tag);
    @(negedge clk);
  endtask

  task automatic resetTallies;
    stallSeen = 0; bubbleSeen = 0; flushSeen = 0;
  endtask

  initial begin
    tests = 0; fails = 0;
    memOutstanding = 0; mdOutstanding = 0; flushOwed = 0; stallTotal = 32'd0;
    rst_n = 1'b0;
    clearInputs();
    @(negedge clk);

    // Reset holds outputs low even with every hazard input active
    mem_req = 1'b1; md_start = 1'b1; branch_flush = 1'b1;
    ex_mem_read = 1'b1; ex_reg_wen = 1'b1; ex_rd = 5'd3; id_rs1 = 5'd3; id_rs1_used = 1'b1;
    applyStimulus("reset_forced");
    clearInputs();
    applyStimulus("reset_idle");
    rst_n = 1'b1;
    applyStimulus("run_idle");

    // Load-use on rs2: exactly one stall+bubble, then the load moves on
    resetTallies();
    ex_mem_read = 1'b1; ex_reg_wen = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_rs2_used = 1'b1;
    applyStimulus("lu_rs2");
    clearInputs();
    applyStimulus("lu_after");
    checkVal("lu_stall_cycles", stallSeen, 1);
    checkVal("lu_bubble_cycles", bubbleSeen, 1);

    // Load-use against x0 is not a hazard
    ex_mem_read = 1'b1; ex_reg_wen = 1'b1; ex_rd = 5'd0; id_rs2 = 5'd0; id_rs2_used = 1'b1;
    applyStimulus("lu_x0");
    clearInputs();

    // Memory wait: 3 waiting cycles, request dropped mid-wait, then ready
    resetTallies();
    mem_req = 1'b1;
    applyStimulus("mem_w1");
    applyStimulus("mem_w2");
    mem_req = 1'b0;
    applyStimulus("mem_w3");
    mem_ready = 1'b1;
    applyStimulus("mem_ready");
    clearInputs();
    applyStimulus("mem_after");
    checkVal("mem_stall_cycles", stallSeen, 3);

    // Mul/div: start pulse, done four cycles later
    resetTallies();
    md_start = 1'b1;
    applyStimulus("md_w1");
    md_start = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus("md_wait");
    md_done = 1'b1;
    applyStimulus("md_done");
    clearInputs();
    checkVal("md_stall_cycles", stallSeen, 4);

    // Same-cycle start/done and req/ready produce no stall
    md_start = 1'b1; md_done = 1'b1; mem_req = 1'b1; mem_ready = 1'b1;
    applyStimulus("same_cycle");
    clearInputs();
    applyStimulus("same_cycle_after");

    // Deferred flush: branch during cycle 2 of a 5-cycle memory wait
    resetTallies();
    mem_req = 1'b1;
    applyStimulus("dfl_w1");
    branch_flush = 1'b1;
    applyStimulus("dfl_w2");
    branch_flush = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus("dfl_wait");
    checkVal("dfl_no_flush_in_wait", flushSeen, 0);
    mem_ready = 1'b1;
    applyStimulus("dfl_ready");
    clearInputs();
    applyStimulus("dfl_after");
    checkVal("dfl_flush_cycles", flushSeen, 1);

    // Flush beats load-use
    branch_flush = 1'b1;
    ex_mem_read = 1'b1; ex_reg_wen = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9; id_rs1_used = 1'b1;
    applyStimulus("flush_vs_lu");
    clearInputs();

    // Reset in the middle of a mul/div wait, then seven stall cycles
    md_start = 1'b1;
    applyStimulus("rmd_w1");
    md_start = 1'b0;
    applyStimulus("rmd_w2");
    rst_n = 1'b0;
    applyStimulus("rmd_reset");
    rst_n = 1'b1;
    applyStimulus("rmd_released");
    mem_req = 1'b1;
    for (int i = 0; i < 7; i++) applyStimulus("perf_wait");
    mem_ready = 1'b1;
    applyStimulus("perf_ready");
    clearInputs();
`ifdef YSYX_22040125_STALL_PERF_EN
    #1;
    checkVal("perf_seven", perf_stall_cnt, 32'd7);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      rst_n        = ($urandom_range(0, 59) != 0);
      md_start     = ($urandom_range(0, 9) == 0);
      md_done      = ($urandom_range(0, 3) == 0);
      mem_req      = ($urandom_range(0, 3) == 0);
      mem_ready    = ($urandom_range(0, 2) == 0);
      branch_flush = ($urandom_range(0, 7) == 0);
      ex_mem_read  = 1'($urandom_range(0, 1));
      ex_reg_wen   = 1'($urandom_range(0, 1));
      ex_rd        = 5'($urandom_range(0, 3));
      id_rs1       = 5'($urandom_range(0, 3));
      id_rs2       = 5'($urandom_range(0, 3));
      id_rs1_used  = 1'($urandom_range(0, 1));
      id_rs2_used  = 1'($urandom_range(0, 1));
      applyStimulus("random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
